// File: rtl/mux_2to4_if.sv
// Select/decode bus for mux_2to4: select code and controls in, one-hot lines,
// valid flag and packed hit counters out.
interface mux_2to4_if #(
    parameter int COUNT_W = 8
);
    logic [1:0]           In;
    logic                 en;
    logic                 cnt_clr;
    logic [3:0]           Out;
    logic                 out_valid;
    logic [4*COUNT_W-1:0] hit_cnt;

    // master drives the select side, slave is the decoder
    modport master (
        output In, en, cnt_clr,
        input  Out, out_valid, hit_cnt
    );
    modport slave (
        input  In, en, cnt_clr,
        output Out, out_valid, hit_cnt
    );
endinterface

// File: rtl/mux_2to4.sv
// Registered 2-to-4 one-hot decoder with enable and saturating per-line hit counters.
// Every output is a flop; no combinational input-to-output path exists.
module mux_2to4 #(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int COUNT_W    = 8
) (
    input logic        clk,
    input logic        rst_n,
    mux_2to4_if.slave  bus
);
    localparam logic [3:0]         IDLE    = ACTIVE_LOW ? 4'b1111 : 4'b0000;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [3:0]         dec;
    logic [3:0]         out_q;
    logic               valid_q;
    logic [COUNT_W-1:0] cnt_q [4];

    // XOR with the idle pattern turns the active-high one-hot into active-low when needed
    always_comb begin
        dec = (4'b0001 << bus.In) ^ IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= IDLE;
            valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            out_q   <= bus.en ? dec : IDLE;
            valid_q <= bus.en;
            // clear wins over a same-cycle increment; counters stick at all-ones
            for (int k = 0; k < 4; k++) begin
                if (bus.cnt_clr) begin
                    cnt_q[k] <= '0;
                end else if (bus.en && (bus.In == k[1:0]) && (cnt_q[k] != CNT_MAX)) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign bus.Out       = out_q;
    assign bus.out_valid = valid_q;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign bus.hit_cnt[g*COUNT_W +: COUNT_W] = cnt_q[g];
    end
endmodule

// File: tb/tb_mux_2to4.sv
// Bench for mux_2to4: three instances (default, 3-bit counters, active-low)
// share one stimulus stream; checks are table-driven plus hand sequences.
module tb_mux_2to4;
    logic clk;
    logic rst_n;

    mux_2to4_if #(.COUNT_W(8)) bif_a ();
    mux_2to4_if #(.COUNT_W(3)) bif_s ();
    mux_2to4_if #(.COUNT_W(8)) bif_l ();

    mux_2to4 #(.ACTIVE_LOW(1'b0), .COUNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bif_a.slave));
    mux_2to4 #(.ACTIVE_LOW(1'b0), .COUNT_W(3)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bif_s.slave));
    mux_2to4 #(.ACTIVE_LOW(1'b1), .COUNT_W(8)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bif_l.slave));

    int n_vec;
    int n_bad;

    typedef struct {
        logic [1:0] in;
        logic       en;
        int         reps;
        logic [3:0] exp_out;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [5];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] in, input logic en, input logic clr);
        bif_a.In = in; bif_a.en = en; bif_a.cnt_clr = clr;
        bif_s.In = in; bif_s.en = en; bif_s.cnt_clr = clr;
        bif_l.In = in; bif_l.en = en; bif_l.cnt_clr = clr;
    endtask

    // drive at the falling edge, let one rising edge load, sample at the next falling edge
    task automatic step(input logic [1:0] in, input logic en, input logic clr);
        drive(in, en, clr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cnts(input string name, input int ea0, input int ea1, input int ea2,
                              input int ea3, input int es0, input int es1, input int es2,
                              input int es3);
        check({name, " a0"}, 32'(bif_a.hit_cnt[7:0]),   32'(ea0));
        check({name, " a1"}, 32'(bif_a.hit_cnt[15:8]),  32'(ea1));
        check({name, " a2"}, 32'(bif_a.hit_cnt[23:16]), 32'(ea2));
        check({name, " a3"}, 32'(bif_a.hit_cnt[31:24]), 32'(ea3));
        check({name, " s0"}, 32'(bif_s.hit_cnt[2:0]),   32'(es0));
        check({name, " s1"}, 32'(bif_s.hit_cnt[5:3]),   32'(es1));
        check({name, " s2"}, 32'(bif_s.hit_cnt[8:6]),   32'(es2));
        check({name, " s3"}, 32'(bif_s.hit_cnt[11:9]),  32'(es3));
    endtask

    task automatic check_out(input string name, input logic [3:0] exp_hi, input logic [3:0] exp_lo,
                             input logic exp_valid);
        check({name, " out"},     32'(bif_a.Out),       32'(exp_hi));
        check({name, " valid"},   32'(bif_a.out_valid), 32'(exp_valid));
        check({name, " out_lo"},  32'(bif_l.Out),       32'(exp_lo));
        check({name, " valid_lo"},32'(bif_l.out_valid), 32'(exp_valid));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        vecs[0] = '{in: 2'd0, en: 1'b1, reps: 10, exp_out: 4'b0001, exp_valid: 1'b1};
        vecs[1] = '{in: 2'd1, en: 1'b1, reps: 10, exp_out: 4'b0010, exp_valid: 1'b1};
        vecs[2] = '{in: 2'd2, en: 1'b1, reps: 10, exp_out: 4'b0100, exp_valid: 1'b1};
        vecs[3] = '{in: 2'd3, en: 1'b1, reps: 10, exp_out: 4'b1000, exp_valid: 1'b1};
        vecs[4] = '{in: 2'd2, en: 1'b0, reps: 1,  exp_out: 4'b0000, exp_valid: 1'b0};

        // reset values
        drive(2'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_out("reset", 4'b0000, 4'b1111, 1'b0);
        check_cnts("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // table: walk codes 0..3 with enable, then disable on code 2
        for (int v = 0; v < 5; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                step(vecs[v].in, vecs[v].en, 1'b0);
                check_out($sformatf("vec%0d.%0d", v, r), vecs[v].exp_out, ~vecs[v].exp_out,
                          vecs[v].exp_valid);
            end
        end
        // 10 hits per line; the 3-bit counters stuck at 7
        check_cnts("after walk", 10, 10, 10, 10, 7, 7, 7, 7);

        // clear while disabled leaves Out idle
        step(2'd0, 1'b0, 1'b1);
        check_out("clr idle", 4'b0000, 4'b1111, 1'b0);
        check_cnts("clr idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // saturation: code 1 for 12 cycles
        for (int i = 1; i <= 12; i++) begin
            step(2'd1, 1'b1, 1'b0);
            check(
                $sformatf("sat s1 cyc%0d", i), 32'(bif_s.hit_cnt[5:3]), (i < 7) ? 32'(i) : 32'd7);
        end
        check_cnts("sat", 0, 12, 0, 0, 0, 7, 0, 0);

        // clear together with an enabled decode
        step(2'd3, 1'b1, 1'b1);
        check_out("clr+en", 4'b1000, 4'b0111, 1'b1);
        check_cnts("clr+en", 0, 0, 0, 0, 0, 0, 0, 0);

        // asynchronous reset between edges while Out shows code 2
        step(2'd2, 1'b1, 1'b0);
        check_out("pre rst", 4'b0100, 4'b1011, 1'b1);
        check_cnts("pre rst", 0, 0, 1, 0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check_out("async rst", 4'b0000, 4'b1111, 1'b0);
        check_cnts("async rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // first edge after release is a normal cycle
        step(2'd1, 1'b1, 1'b0);
        check_out("post rst", 4'b0010, 4'b1101, 1'b1);
        check_cnts("post rst", 0, 1, 0, 0, 0, 1, 0, 0);

        // back-to-back code changes on consecutive cycles
        step(2'd0, 1'b1, 1'b0);
        check_out("b2b 0", 4'b0001, 4'b1110, 1'b1);
        step(2'd3, 1'b1, 1'b0);
        check_out("b2b 3", 4'b1000, 4'b0111, 1'b1);
        step(2'd2, 1'b1, 1'b0);
        check_out("b2b 2", 4'b0100, 4'b1011, 1'b1);
        check_cnts("b2b", 1, 1, 1, 1, 1, 1, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
